// File: rtl/pc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_pkg
// Description : Shared constants and types for the program counter block:
//               data width, default reset vector and step, and the
//               next-PC select encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package pc_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
    localparam int unsigned     PC_STEP_DEFAULT      = 4;

    // Source of the next program counter value.
    typedef enum logic [1:0] {
        SEL_JUMP   = 2'd0,
        SEL_BRANCH = 2'd1,
        SEL_HOLD   = 2'd2,
        SEL_INC    = 2'd3
    } pc_sel_e;

endpackage : pc_pkg
`default_nettype wire

// File: rtl/pc_next_calc.sv
`default_nettype none
// ============================================================================
// Module      : pc_next_calc
// Description : Purely combinational next-PC logic. Chooses the next-PC
//               source by priority (jump, branch, stall, advance), forms
//               the word-aligned next PC and flags a misaligned redirect.
// Config      : PC_BRANCH_EN - when defined, adds the PC-relative branch
//               inputs and the branch adder.
// Ports       : pc_i            current program counter
//               stall_i         hold the PC unless redirected
//               jump_valid_i    absolute redirect request
//               jump_target_i   absolute redirect address
//               branch_taken_i  relative redirect request  (PC_BRANCH_EN)
//               branch_offset_i signed relative offset     (PC_BRANCH_EN)
//               next_pc_o       value to load on the next clock edge
//               misalign_o      redirect target had nonzero bits [1:0]
// Revision    : 1.0 - initial release
// ============================================================================
module pc_next_calc
    import pc_pkg::*;
#(
    parameter int unsigned PC_STEP = PC_STEP_DEFAULT
) (
    input  logic [XLEN-1:0] pc_i,
    input  logic            stall_i,
    input  logic            jump_valid_i,
    input  logic [XLEN-1:0] jump_target_i,
`ifdef PC_BRANCH_EN
    input  logic            branch_taken_i,
    input  logic [XLEN-1:0] branch_offset_i,
`endif
    output logic [XLEN-1:0] next_pc_o,
    output logic            misalign_o
);

    pc_sel_e w_sel;

`ifdef PC_BRANCH_EN
    // Unmasked branch target; low bits are needed for the misalign flag.
    logic [XLEN-1:0] w_branch_tgt;
    assign w_branch_tgt = pc_i + branch_offset_i;
`endif

    always_comb begin
        w_sel = SEL_INC;
        if (jump_valid_i) begin
            w_sel = SEL_JUMP;
`ifdef PC_BRANCH_EN
        end else if (branch_taken_i) begin
            w_sel = SEL_BRANCH;
`endif
        end else if (stall_i) begin
            w_sel = SEL_HOLD;
        end
    end

    always_comb begin
        next_pc_o  = pc_i + XLEN'(PC_STEP);
        misalign_o = 1'b0;
        case (w_sel)
            SEL_JUMP: begin
                next_pc_o  = {jump_target_i[XLEN-1:2], 2'b00};
                misalign_o = |jump_target_i[1:0];
            end
`ifdef PC_BRANCH_EN
            SEL_BRANCH: begin
                next_pc_o  = {w_branch_tgt[XLEN-1:2], 2'b00};
                misalign_o = |w_branch_tgt[1:0];
            end
`endif
            SEL_HOLD: begin
                next_pc_o = pc_i;
            end
            default: begin
                next_pc_o = pc_i + XLEN'(PC_STEP);
            end
        endcase
    end

endmodule : pc_next_calc
`default_nettype wire

// File: rtl/pc.sv
`default_nettype none
// ============================================================================
// Module      : pc
// Description : Program counter register. Holds the registered PC and the
//               one-cycle misalign flag; next-state logic lives in
//               pc_next_calc.
// Config      : PC_BRANCH_EN - when defined, exposes branch_taken and
//               branch_offset and enables the PC-relative branch path.
// Ports       : clk           rising-edge clock
//               reset         asynchronous active-low reset
//               stall         hold PC unless a redirect is requested
//               jump_valid    absolute redirect request
//               jump_target   absolute redirect byte address
//               branch_taken  relative redirect request  (PC_BRANCH_EN)
//               branch_offset signed byte offset         (PC_BRANCH_EN)
//               output_PC     registered program counter
//               misalign      registered misaligned-redirect flag
// Revision    : 1.0 - initial release
// ============================================================================
module pc
    import pc_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
    parameter int unsigned     PC_STEP      = PC_STEP_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            jump_valid,
    input  logic [XLEN-1:0] jump_target,
`ifdef PC_BRANCH_EN
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_offset,
`endif
    output logic [XLEN-1:0] output_PC,
    output logic            misalign
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;
    logic            misalign_q;
    logic            misalign_d;

    pc_next_calc #(
        .PC_STEP         (PC_STEP)
    ) u_next_calc (
        .pc_i            (pc_q),
        .stall_i         (stall),
        .jump_valid_i    (jump_valid),
        .jump_target_i   (jump_target),
`ifdef PC_BRANCH_EN
        .branch_taken_i  (branch_taken),
        .branch_offset_i (branch_offset),
`endif
        .next_pc_o       (pc_d),
        .misalign_o      (misalign_d)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q       <= RESET_VECTOR;
            misalign_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
        end
    end

    assign output_PC = pc_q;
    assign misalign  = misalign_q;

endmodule : pc
`default_nettype wire

// File: tb/tb_pc.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc
// Description : Directed self-checking bench for the pc block.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        jump_valid;
    logic [31:0] jump_target;
`ifdef PC_BRANCH_EN
    logic        branch_taken;
    logic [31:0] branch_offset;
`endif
    logic [31:0] output_PC;
    logic        misalign;

    int pass_cnt  = 0;
    int total_cnt = 0;

    pc dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .jump_valid    (jump_valid),
        .jump_target   (jump_target),
`ifdef PC_BRANCH_EN
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
`endif
        .output_PC     (output_PC),
        .misalign      (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] exp;
        #1 reset = 1'b0;
        #1;
        total_cnt++;
        if (output_PC !== 32'h0) $display("FAIL reset_pc: output_PC=%h expected %h", output_PC, 32'h0);
        else pass_cnt++;
        total_cnt++;
        if (misalign !== 1'b0) $display("FAIL reset_misalign: misalign=%b expected 0", misalign);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (output_PC !== 32'h0) $display("FAIL reset_hold_edge: output_PC=%h expected %h", output_PC, 32'h0);
        else pass_cnt++;
        reset = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            exp = 32'(i * 4);
            total_cnt++;
            if (output_PC !== exp) $display("FAIL free_run[%0d]: output_PC=%h expected %h", i, output_PC, exp);
            else pass_cnt++;
        end
    endtask

    task automatic test_stall();
        reset = 1'b0;
        #1 reset = 1'b1;
        tick();
        tick();
        total_cnt++;
        if (output_PC !== 32'd8) $display("FAIL stall_start: output_PC=%h expected %h", output_PC, 32'd8);
        else pass_cnt++;
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total_cnt++;
            if (output_PC !== 32'd8) $display("FAIL stall_hold[%0d]: output_PC=%h expected %h", i, output_PC, 32'd8);
            else pass_cnt++;
        end
        stall = 1'b0;
        tick();
        total_cnt++;
        if (output_PC !== 32'd12) $display("FAIL stall_release: output_PC=%h expected %h", output_PC, 32'd12);
        else pass_cnt++;
    endtask

    task automatic test_jump();
        tick();
        total_cnt++;
        if (output_PC !== 32'd16) $display("FAIL jump_start: output_PC=%h expected %h", output_PC, 32'd16);
        else pass_cnt++;
        jump_valid  = 1'b1;
        jump_target = 32'h100;
        tick();
        jump_valid = 1'b0;
        total_cnt++;
        if (output_PC !== 32'h100) $display("FAIL jump_taken: output_PC=%h expected %h", output_PC, 32'h100);
        else pass_cnt++;
        total_cnt++;
        if (misalign !== 1'b0) $display("FAIL jump_misalign: misalign=%b expected 0", misalign);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (output_PC !== 32'h104) $display("FAIL jump_after: output_PC=%h expected %h", output_PC, 32'h104);
        else pass_cnt++;
        // A stall alongside a jump must not block the jump.
        stall       = 1'b1;
        jump_valid  = 1'b1;
        jump_target = 32'h40;
        tick();
        stall      = 1'b0;
        jump_valid = 1'b0;
        total_cnt++;
        if (output_PC !== 32'h40) $display("FAIL jump_over_stall: output_PC=%h expected %h", output_PC, 32'h40);
        else pass_cnt++;
    endtask

`ifdef PC_BRANCH_EN
    task automatic test_branch();
        jump_valid  = 1'b1;
        jump_target = 32'h100;
        tick();
        jump_valid = 1'b0;
        branch_taken  = 1'b1;
        branch_offset = -32'sd8;
        tick();
        total_cnt++;
        if (output_PC !== 32'hF8) $display("FAIL branch_back: output_PC=%h expected %h", output_PC, 32'hF8);
        else pass_cnt++;
        // Jump beats branch; the branch offset would have been misaligned.
        branch_offset = 32'd1;
        jump_valid    = 1'b1;
        jump_target   = 32'h40;
        tick();
        jump_valid = 1'b0;
        total_cnt++;
        if (output_PC !== 32'h40) $display("FAIL branch_vs_jump: output_PC=%h expected %h", output_PC, 32'h40);
        else pass_cnt++;
        total_cnt++;
        if (misalign !== 1'b0) $display("FAIL branch_vs_jump_misalign: misalign=%b expected 0", misalign);
        else pass_cnt++;
        branch_offset = 32'd2;
        tick();
        total_cnt++;
        if (output_PC !== 32'h40 || misalign !== 1'b1)
            $display("FAIL branch_misalign: output_PC=%h misalign=%b expected %h/1", output_PC, misalign, 32'h40);
        else pass_cnt++;
        stall         = 1'b1;
        branch_offset = 32'h10;
        tick();
        stall        = 1'b0;
        branch_taken = 1'b0;
        total_cnt++;
        if (output_PC !== 32'h50 || misalign !== 1'b0)
            $display("FAIL branch_over_stall: output_PC=%h misalign=%b expected %h/0", output_PC, misalign, 32'h50);
        else pass_cnt++;
    endtask
`endif

    task automatic test_misalign();
        jump_valid  = 1'b1;
        jump_target = 32'h203;
        tick();
        jump_valid = 1'b0;
        total_cnt++;
        if (output_PC !== 32'h200) $display("FAIL misalign_pc: output_PC=%h expected %h", output_PC, 32'h200);
        else pass_cnt++;
        total_cnt++;
        if (misalign !== 1'b1) $display("FAIL misalign_set: misalign=%b expected 1", misalign);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (output_PC !== 32'h204 || misalign !== 1'b0)
            $display("FAIL misalign_clear: output_PC=%h misalign=%b expected %h/0", output_PC, misalign, 32'h204);
        else pass_cnt++;
    endtask

    task automatic test_wrap();
        jump_valid  = 1'b1;
        jump_target = 32'hFFFF_FFFF;
        tick();
        jump_valid = 1'b0;
        total_cnt++;
        if (output_PC !== 32'hFFFF_FFFC || misalign !== 1'b1)
            $display("FAIL wrap_top: output_PC=%h misalign=%b expected %h/1", output_PC, misalign, 32'hFFFF_FFFC);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (output_PC !== 32'h0 || misalign !== 1'b0)
            $display("FAIL wrap_zero: output_PC=%h misalign=%b expected %h/0", output_PC, misalign, 32'h0);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (output_PC !== 32'h4) $display("FAIL wrap_next: output_PC=%h expected %h", output_PC, 32'h4);
        else pass_cnt++;
    endtask

    task automatic test_async_reset();
        // Leave misalign set so the async clear of both registers is visible.
        jump_valid  = 1'b1;
        jump_target = 32'h203;
        tick();
        jump_target = 32'h500;
`ifdef PC_BRANCH_EN
        jump_valid    = 1'b0;
        branch_taken  = 1'b1;
        branch_offset = 32'h80;
`endif
        #2 reset = 1'b0;
        #1;
        total_cnt++;
        if (output_PC !== 32'h0 || misalign !== 1'b0)
            $display("FAIL async_reset: output_PC=%h misalign=%b expected %h/0", output_PC, misalign, 32'h0);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (output_PC !== 32'h0) $display("FAIL async_reset_edge: output_PC=%h expected %h", output_PC, 32'h0);
        else pass_cnt++;
        jump_valid = 1'b0;
`ifdef PC_BRANCH_EN
        branch_taken = 1'b0;
`endif
        reset = 1'b1;
        tick();
        total_cnt++;
        if (output_PC !== 32'h4 || misalign !== 1'b0)
            $display("FAIL async_reset_release: output_PC=%h misalign=%b expected %h/0", output_PC, misalign, 32'h4);
        else pass_cnt++;
    endtask

    initial begin
        reset       = 1'b1;
        stall       = 1'b0;
        jump_valid  = 1'b0;
        jump_target = 32'h0;
`ifdef PC_BRANCH_EN
        branch_taken  = 1'b0;
        branch_offset = 32'h0;
`endif
        test_reset();
        test_stall();
        test_jump();
`ifdef PC_BRANCH_EN
        test_branch();
`endif
        test_misalign();
        test_wrap();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule : tb_pc
`default_nettype wire
